// File: rtl/c7bicu_pkg.sv
// c7bicu_pkg: shared definitions for the c7bicu instruction cache unit.
//   - state_e       : controller state encoding
//   - LINE_BYTES    : bytes per cache line (one 64-bit fetch block)
//   - tag_bits()    : tag width derived from the index width
package c7bicu_pkg;

    localparam int unsigned ADDR_BITS  = 32;
    localparam int unsigned LINE_BYTES = 8;
    localparam int unsigned LINE_BITS  = LINE_BYTES * 8;
    localparam int unsigned OFF_BITS   = 3;
    // Block address = addr[31:3]
    localparam int unsigned BLK_BITS   = ADDR_BITS - OFF_BITS;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLookup   = 2'd1,
        StMissReq  = 2'd2,
        StMissWait = 2'd3
    } state_e;

    function automatic int unsigned tag_bits(input int unsigned idx_bits);
        return BLK_BITS - idx_bits;
    endfunction

endpackage

// File: rtl/c7bicu_array.sv
// c7bicu_array: direct-mapped line storage (valid bits, tags, 64-bit data).
// Ports:
//   clk, reset          : clock, synchronous active-high reset (valid bits only)
//   inv                 : flash-clear all valid bits at the clock edge
//   rd_idx              : combinational read index
//   rd_valid/tag/data   : contents of line rd_idx
//   wr_en, wr_idx       : line write strobe and index
//   wr_tag, wr_data     : tag and data to store
//   wr_set_valid        : value written into the line's valid bit
module c7bicu_array
    import c7bicu_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inv,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 wr_set_valid
);

    localparam int unsigned LINES = 1 << IDX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    // Invalidate wins over a same-cycle refill so the refilled line stays invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inv) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_set_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_data  = data_q[rd_idx];
    end

endmodule

// File: rtl/c7bicu.sv
// c7bicu: instruction cache unit, responder side of the IFU fetch interface.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   ifu_icu_req_ic1/addr_ic1  : fetch request and address (addr[2:0] ignored)
//   icu_ifu_ack_ic1           : request accepted this cycle
//   icu_ifu_data_valid_ic2    : returned block valid
//   icu_ifu_data_ic2          : 8-byte block holding the accepted address
//   icu_inv                   : invalidate all lines
//   icu_biu_req/addr          : refill read request and block-aligned address
//   biu_icu_ack               : BIU accepted the refill request
//   biu_icu_data_vld/data     : refill data return
module c7bicu
    import c7bicu_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ifu_icu_req_ic1,
    input  logic [ADDR_BITS-1:0] ifu_icu_addr_ic1,
    output logic                 icu_ifu_ack_ic1,
    output logic                 icu_ifu_data_valid_ic2,
    output logic [LINE_BITS-1:0] icu_ifu_data_ic2,
    input  logic                 icu_inv,
    output logic                 icu_biu_req,
    output logic [ADDR_BITS-1:0] icu_biu_addr,
    input  logic                 biu_icu_ack,
    input  logic                 biu_icu_data_vld,
    input  logic [LINE_BITS-1:0] biu_icu_data
);

    localparam int unsigned TAG_BITS = tag_bits(IDX_BITS);

    state_e              state_q;
    logic [BLK_BITS-1:0] blk_q;
    logic                inv_pend_q;

    logic [IDX_BITS-1:0]  idx_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic                 rd_valid;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 hit;
    logic                 refill;
    logic                 wr_en;
    logic                 unused_addr_bits;

    assign idx_q            = blk_q[IDX_BITS-1:0];
    assign tag_q            = blk_q[BLK_BITS-1:IDX_BITS];
    assign unused_addr_bits = ^ifu_icu_addr_ic1[OFF_BITS-1:0];

    c7bicu_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .inv          (icu_inv),
        .rd_idx       (idx_q),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_idx       (idx_q),
        .wr_tag       (tag_q),
        .wr_data      (biu_icu_data),
        .wr_set_valid (!inv_pend_q)
    );

    // Lookup reads pre-edge valid bits, so a same-cycle icu_inv does not affect it.
    always_comb begin
        hit    = (state_q == StLookup) && rd_valid && (rd_tag == tag_q);
        refill = (state_q == StMissWait) && biu_icu_data_vld;
        wr_en  = refill && !reset;

        icu_ifu_ack_ic1 = !reset && ifu_icu_req_ic1 && ((state_q == StIdle) || hit);

        // Refill data bypasses the array straight to the IFU.
        icu_ifu_data_valid_ic2 = !reset && (hit || refill);
        icu_ifu_data_ic2       = '0;
        if (icu_ifu_data_valid_ic2) begin
            icu_ifu_data_ic2 = refill ? biu_icu_data : rd_data;
        end

        icu_biu_req  = !reset && (state_q == StMissReq);
        icu_biu_addr = icu_biu_req ? {blk_q, {OFF_BITS{1'b0}}} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            if (icu_ifu_ack_ic1) begin
                blk_q <= ifu_icu_addr_ic1[ADDR_BITS-1:OFF_BITS];
            end
            case (state_q)
                StIdle: begin
                    if (icu_ifu_ack_ic1) begin
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (!hit) begin
                        state_q <= StMissReq;
                    end else if (!icu_ifu_ack_ic1) begin
                        state_q <= StIdle;
                    end
                end
                StMissReq: begin
                    if (biu_icu_ack) begin
                        state_q <= StMissWait;
                    end
                    if (icu_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                end
                StMissWait: begin
                    if (biu_icu_data_vld) begin
                        state_q    <= StIdle;
                        inv_pend_q <= 1'b0;
                    end else if (icu_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_c7bicu.sv
// tb_c7bicu: directed scoreboard bench for c7bicu. Stimulus pushes the expected
// block for every accepted fetch; a monitor pops and checks on each data_valid.
module tb_c7bicu;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_icu_req_ic1;
    logic [31:0] ifu_icu_addr_ic1;
    logic        icu_ifu_ack_ic1;
    logic        icu_ifu_data_valid_ic2;
    logic [63:0] icu_ifu_data_ic2;
    logic        icu_inv;
    logic        icu_biu_req;
    logic [31:0] icu_biu_addr;
    logic        biu_icu_ack;
    logic        biu_icu_data_vld;
    logic [63:0] biu_icu_data;

    typedef struct {
        logic [63:0] data;
        bit          hit;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   biu_cnt = 0;

    localparam logic [63:0] D0   = 64'h0000_0013_0280_0400;
    localparam logic [63:0] D8   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D200 = 64'hdead_beef_0bad_f00d;

    c7bicu dut (
        .clk                    (clk),
        .reset                  (reset),
        .ifu_icu_req_ic1        (ifu_icu_req_ic1),
        .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
        .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
        .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
        .icu_ifu_data_ic2       (icu_ifu_data_ic2),
        .icu_inv                (icu_inv),
        .icu_biu_req            (icu_biu_req),
        .icu_biu_addr           (icu_biu_addr),
        .biu_icu_ack            (biu_icu_ack),
        .biu_icu_data_vld       (biu_icu_data_vld),
        .biu_icu_data           (biu_icu_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (icu_biu_req && biu_icu_ack) biu_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reset-state outputs and the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("reset_ack", icu_ifu_ack_ic1, 0);
            check("reset_dvld", icu_ifu_data_valid_ic2, 0);
            check("reset_data", icu_ifu_data_ic2, 0);
            check("reset_biu_req", icu_biu_req, 0);
            check("reset_biu_addr", icu_biu_addr, 0);
        end
        if (icu_ifu_data_valid_ic2) begin
            if (exp_q.size() == 0) begin
                check("spurious_dvld", icu_ifu_data_valid_ic2, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", icu_ifu_data_ic2, e.data);
                if (e.hit) check("hit_latency", 64'(cyc - e.cyc), 1);
                else       check("miss_bypass", biu_icu_data_vld, 1);
            end
        end
    end

    // Present one fetch; returns at posedge+1 of the accepting edge.
    task automatic fetch(input logic [31:0] a, input logic [63:0] d, input bit hit,
                         input bit keep);
        int   waits = 0;
        exp_t e;
        ifu_icu_req_ic1  = 1'b1;
        ifu_icu_addr_ic1 = a;
        @(negedge clk);
        while (!icu_ifu_ack_ic1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("ack_wait", 64'(waits), 0);
        if (icu_ifu_ack_ic1) begin
            e.data = d;
            e.hit  = hit;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            ifu_icu_req_ic1  = 1'b0;
            ifu_icu_addr_ic1 = '0;
        end
    endtask

    task automatic wait_biu_req(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!icu_biu_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = icu_biu_req;
        check("biu_req_seen", icu_biu_req, 1);
    endtask

    task automatic biu_serve(input logic [31:0] exp_addr, input logic [63:0] d,
                             input int ack_dly, input int data_dly, input bit inv_wait);
        bit ok;
        wait_biu_req(ok);
        if (!ok) return;
        check("biu_addr", icu_biu_addr, exp_addr);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check("biu_addr_stable", {icu_biu_req, icu_biu_addr}, {1'b1, exp_addr});
        end
        @(posedge clk);
        #1 biu_icu_ack = 1'b1;
        @(posedge clk);
        #1 biu_icu_ack = 1'b0;
        if (inv_wait) begin
            icu_inv = 1'b1;
            @(posedge clk);
            #1 icu_inv = 1'b0;
        end
        repeat (data_dly - 1) @(posedge clk);
        #1;
        biu_icu_data_vld = 1'b1;
        biu_icu_data     = d;
        @(posedge clk);
        #1;
        biu_icu_data_vld = 1'b0;
        biu_icu_data     = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset            = 1'b1;
        ifu_icu_req_ic1  = 1'b1;
        ifu_icu_addr_ic1 = 32'h1c00_0000;
        icu_inv          = 1'b0;
        biu_icu_ack      = 1'b0;
        biu_icu_data_vld = 1'b0;
        biu_icu_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset           = 1'b0;
        ifu_icu_req_ic1 = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then hit on the same block.
        fetch(32'h1c00_0000, D0, 0, 0);
        biu_serve(32'h1c00_0000, D0, 2, 3, 0);
        drain();
        fetch(32'h1c00_0004, D0, 1, 0);
        drain();
        check("biu_cnt_hit", 64'(biu_cnt), 1);

        // Fill a second block, then stream hits back to back.
        fetch(32'h1c00_0008, D8, 0, 0);
        biu_serve(32'h1c00_0008, D8, 0, 2, 0);
        drain();
        fetch(32'h1c00_0000, D0, 1, 1);
        fetch(32'h1c00_0008, D8, 1, 1);
        fetch(32'h1c00_0004, D0, 1, 1);
        fetch(32'h1c00_000c, D8, 1, 0);
        drain();
        check("biu_cnt_stream", 64'(biu_cnt), 2);

        // Conflict on index 0.
        fetch(32'h1c00_0200, D200, 0, 0);
        biu_serve(32'h1c00_0200, D200, 1, 2, 0);
        drain();
        fetch(32'h1c00_0000, D0, 0, 0);
        biu_serve(32'h1c00_0000, D0, 1, 2, 0);
        drain();
        check("biu_cnt_conflict", 64'(biu_cnt), 4);

        // Invalidate while idle.
        icu_inv = 1'b1;
        @(posedge clk);
        #1 icu_inv = 1'b0;
        fetch(32'h1c00_0000, D0, 0, 0);
        biu_serve(32'h1c00_0000, D0, 0, 2, 0);
        drain();
        check("biu_cnt_inv", 64'(biu_cnt), 5);

        // Invalidate during MISS_WAIT: data still returned, line stays invalid.
        fetch(32'h1c00_0008, D8, 0, 0);
        biu_serve(32'h1c00_0008, D8, 0, 3, 1);
        drain();
        fetch(32'h1c00_0008, D8, 0, 0);
        biu_serve(32'h1c00_0008, D8, 0, 2, 0);
        drain();
        fetch(32'h1c00_000c, D8, 1, 0);
        drain();
        check("biu_cnt_inv_wait", 64'(biu_cnt), 7);

        // Reset during MISS_WAIT; a late refill beat must be ignored.
        fetch(32'h1c00_0200, D200, 0, 0);
        wait_biu_req(ok);
        @(posedge clk);
        #1 biu_icu_ack = 1'b1;
        @(posedge clk);
        #1 biu_icu_ack = 1'b0;
        reset            = 1'b1;
        ifu_icu_req_ic1  = 1'b1;
        ifu_icu_addr_ic1 = 32'h1c00_0000;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset            = 1'b0;
        ifu_icu_req_ic1  = 1'b0;
        biu_icu_data_vld = 1'b1;
        biu_icu_data     = D200;
        @(negedge clk);
        check("late_refill_dvld", icu_ifu_data_valid_ic2, 0);
        @(posedge clk);
        #1;
        biu_icu_data_vld = 1'b0;
        biu_icu_data     = '0;
        fetch(32'h1c00_0000, D0, 0, 0);
        biu_serve(32'h1c00_0000, D0, 1, 2, 0);
        drain();
        check("biu_cnt_reset", 64'(biu_cnt), 9);

        check("final_queue", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
